mdsa_stream_sorter: RTL and testbench

Parametrised successor of the fixed 8x8 / 32-bit multidimensional sorting top. It accepts an N x N matrix of DW-bit keys as a stream of rows and sorts it in place with a shearsort schedule: alternating row and column phases, each phase being an N-step odd-even transposition. It then streams the result out in globally sorted row-major order. Adds valid/ready handshakes, runtime ascending/descending selection, a signed-key option and back-pressure on output. The block sits between the data loader and downstream consumers of the MDSA datapath.

---
 rtl/mdsa_pkg.sv | 23 ++
 rtl/mdsa_cmp_swap.sv | 34 +++
 rtl/mdsa_stream_sorter.sv | 225 ++++++++++++++++++++++
 tb/tb_mdsa_stream_sorter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdsa_pkg.sv
// Shared types and elaboration helpers for the shearsort stream sorter.
package mdsa_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    ROW   = 2'd1,
    COL   = 2'd2,
    DRAIN = 2'd3
  } mdsa_state_e;

  function automatic int mdsa_clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // L+1 row phases interleaved with L column phases.
  function automatic int mdsa_num_phases(input int n);
    return 2 * mdsa_clog2(n) + 1;
  endfunction

endpackage

// File: rtl/mdsa_cmp_swap.sv
// Two-key compare-exchange: lo/hi are the keys for the lower/higher index after the step.
module mdsa_cmp_swap
  import mdsa_pkg::*;
#(
  parameter int DW     = 32,
  parameter bit SIGNED = 1'b0
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          dir,
  output logic [DW-1:0] lo,
  output logic [DW-1:0] hi
);

  logic a_gt_b;
  logic b_gt_a;
  logic swap;

  generate
    if (SIGNED) begin : g_signed
      assign a_gt_b = $signed(a) > $signed(b);
      assign b_gt_a = $signed(b) > $signed(a);
    end else begin : g_unsigned
      assign a_gt_b = a > b;
      assign b_gt_a = b > a;
    end
  endgenerate

  // dir=1 wants the larger key first; equal keys never swap.
  assign swap = dir ? b_gt_a : a_gt_b;
  assign lo   = swap ? b : a;
  assign hi   = swap ? a : b;

endmodule

// File: rtl/mdsa_stream_sorter.sv
// Row-streamed N x N shearsort: load rows, run alternating row/column odd-even phases,
// then stream the snake-ordered result back out in row-major order.
module mdsa_stream_sorter
  import mdsa_pkg::*;
#(
  parameter int N      = 8,
  parameter int DW     = 32,
  parameter bit SIGNED = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] in_data,
  input  logic            desc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N*DW-1:0] out_data,
  output logic            out_last,
  output logic            busy,
  output logic            done,
  output logic [1:0]      dbg_state
);

  localparam int L   = mdsa_clog2(N);
  localparam int NP  = mdsa_num_phases(N);
  localparam int PCW = mdsa_clog2(NP);
  localparam int H   = N / 2;
  localparam logic [L-1:0]   RC_LAST = L'(N - 1);
  localparam logic [PCW-1:0] PC_LAST = PCW'(NP - 1);

  typedef logic [DW-1:0] key_t;

  // Handshake rule: a transfer happens on a rising edge where valid and ready are both high;
  // valid never depends on ready, and out_data is held until its transfer.

  mdsa_state_e    state_q, state_d;
  logic [L-1:0]   rc_q, rc_d;
  logic [L-1:0]   sc_q, sc_d;
  logic [PCW-1:0] pc_q, pc_d;
  logic           desc_q, desc_d;
  logic           done_q, done_d;
  logic           out_valid_q, out_valid_d;
  logic           out_last_q, out_last_d;
  logic           busy_q, busy_d;

  key_t m_q    [N][N];
  key_t m_d    [N][N];
  key_t row_nx [N][N];
  key_t col_nx [N][N];
  key_t row_lo [N][H];
  key_t row_hi [N][H];
  key_t col_lo [N][H];
  key_t col_hi [N][H];

  logic odd_step;
  assign odd_step = sc_q[0];

  // Slot k pairs (2k,2k+1) on even steps and (2k+1,2k+2) on odd steps; the last slot idles on odd steps.
  for (genvar r = 0; r < N; r++) begin : g_line
    for (genvar k = 0; k < H; k++) begin : g_slot
      key_t ra, rb, ca, cb;
      if (k < H - 1) begin : g_mid
        assign ra = odd_step ? m_q[r][2*k+1] : m_q[r][2*k];
        assign rb = odd_step ? m_q[r][2*k+2] : m_q[r][2*k+1];
        assign ca = odd_step ? m_q[2*k+1][r] : m_q[2*k][r];
        assign cb = odd_step ? m_q[2*k+2][r] : m_q[2*k+1][r];
      end else begin : g_end
        assign ra = m_q[r][2*k];
        assign rb = m_q[r][2*k+1];
        assign ca = m_q[2*k][r];
        assign cb = m_q[2*k+1][r];
      end

      mdsa_cmp_swap #(.DW(DW), .SIGNED(SIGNED)) u_row_cs (
        .a   (ra),
        .b   (rb),
        .dir (desc_q ^ 1'(r % 2)),
        .lo  (row_lo[r][k]),
        .hi  (row_hi[r][k])
      );

      mdsa_cmp_swap #(.DW(DW), .SIGNED(SIGNED)) u_col_cs (
        .a   (ca),
        .b   (cb),
        .dir (desc_q),
        .lo  (col_lo[r][k]),
        .hi  (col_hi[r][k])
      );
    end
  end

  always_comb begin
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        row_nx[r][c] = m_q[r][c];
        col_nx[r][c] = m_q[r][c];
      end
    end
    if (!odd_step) begin
      for (int r = 0; r < N; r++) begin
        for (int k = 0; k < H; k++) begin
          row_nx[r][2*k]   = row_lo[r][k];
          row_nx[r][2*k+1] = row_hi[r][k];
          col_nx[2*k][r]   = col_lo[r][k];
          col_nx[2*k+1][r] = col_hi[r][k];
        end
      end
    end else begin
      for (int r = 0; r < N; r++) begin
        for (int k = 0; k < H - 1; k++) begin
          row_nx[r][2*k+1] = row_lo[r][k];
          row_nx[r][2*k+2] = row_hi[r][k];
          col_nx[2*k+1][r] = col_lo[r][k];
          col_nx[2*k+2][r] = col_hi[r][k];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    sc_d    = sc_q;
    pc_d    = pc_q;
    desc_d  = desc_q;
    done_d  = 1'b0;
    m_d     = m_q;
    case (state_q)
      LOAD: begin
        if (in_valid) begin
          for (int j = 0; j < N; j++) m_d[rc_q][j] = in_data[j*DW +: DW];
          if (rc_q == '0) desc_d = desc;
          if (rc_q == RC_LAST) begin
            rc_d    = '0;
            sc_d    = '0;
            pc_d    = '0;
            state_d = ROW;
          end else begin
            rc_d = rc_q + 1'b1;
          end
        end
      end
      ROW: begin
        m_d  = row_nx;
        sc_d = sc_q + 1'b1;
        if (sc_q == RC_LAST) begin
          if (pc_q == PC_LAST) begin
            state_d = DRAIN;
          end else begin
            pc_d    = pc_q + 1'b1;
            state_d = COL;
          end
        end
      end
      COL: begin
        m_d  = col_nx;
        sc_d = sc_q + 1'b1;
        if (sc_q == RC_LAST) begin
          pc_d    = pc_q + 1'b1;
          state_d = ROW;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (rc_q == RC_LAST) begin
            rc_d    = '0;
            done_d  = 1'b1;
            state_d = LOAD;
          end else begin
            rc_d = rc_q + 1'b1;
          end
        end
      end
      default: state_d = LOAD;
    endcase
    out_valid_d = (state_d == DRAIN);
    out_last_d  = (state_d == DRAIN) && (rc_d == RC_LAST);
    busy_d      = (state_d != LOAD) || (rc_d != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= LOAD;
      rc_q        <= '0;
      sc_q        <= '0;
      pc_q        <= '0;
      desc_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) m_q[r][c] <= '0;
      end
    end else begin
      state_q     <= state_d;
      rc_q        <= rc_d;
      sc_q        <= sc_d;
      pc_q        <= pc_d;
      desc_q      <= desc_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      m_q         <= m_d;
    end
  end

  // Odd snake rows hold their keys reversed, so flip them on the way out.
  always_comb begin
    out_data = '0;
    for (int j = 0; j < N; j++) begin
      out_data[j*DW +: DW] = rc_q[0] ? m_q[rc_q][N-1-j] : m_q[rc_q][j];
    end
  end

  assign in_ready  = (state_q == LOAD);
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mdsa_stream_sorter.sv
// Directed bench for the shearsort stream sorter at N=4, N=2 (signed/unsigned) and N=8.
module tb_mdsa_stream_sorter;

  logic clk;
  logic rst;

  logic        in_valid4, in_ready4, desc4, out_valid4, out_ready4, out_last4, busy4, done4;
  logic [31:0] in_data4, out_data4;
  logic [1:0]  st4;

  logic        in_valid2, desc2, out_ready2;
  logic [15:0] in_data2;
  logic        in_ready2s, out_valid2s, out_last2s, busy2s, done2s;
  logic        in_ready2u, out_valid2u, out_last2u, busy2u, done2u;
  logic [15:0] out_data2s, out_data2u;
  logic [1:0]  st2s, st2u;

  logic         in_valid8, in_ready8, desc8, out_valid8, out_ready8, out_last8, busy8, done8;
  logic [255:0] in_data8, out_data8;
  logic [1:0]   st8;

  int checks;
  int errors;
  logic [31:0] exp_q[$];

  mdsa_stream_sorter #(.N(4), .DW(8), .SIGNED(1'b0)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
    .desc(desc4), .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
    .out_last(out_last4), .busy(busy4), .done(done4), .dbg_state(st4)
  );

  mdsa_stream_sorter #(.N(2), .DW(8), .SIGNED(1'b1)) u_dut2s (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2s), .in_data(in_data2),
    .desc(desc2), .out_valid(out_valid2s), .out_ready(out_ready2), .out_data(out_data2s),
    .out_last(out_last2s), .busy(busy2s), .done(done2s), .dbg_state(st2s)
  );

  mdsa_stream_sorter #(.N(2), .DW(8), .SIGNED(1'b0)) u_dut2u (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2u), .in_data(in_data2),
    .desc(desc2), .out_valid(out_valid2u), .out_ready(out_ready2), .out_data(out_data2u),
    .out_last(out_last2u), .busy(busy2u), .done(done2u), .dbg_state(st2u)
  );

  mdsa_stream_sorter #(.N(8), .DW(32), .SIGNED(1'b0)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
    .desc(desc8), .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
    .out_last(out_last8), .busy(busy8), .done(done8), .dbg_state(st8)
  );

  // Clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drivers
  task automatic load4(input logic [7:0] mat[16], input logic d, input bit bub);
    for (int r = 0; r < 4; r++) begin
      in_valid4 = 1'b1;
      desc4     = (r == 0) ? d : ~d;
      for (int j = 0; j < 4; j++) in_data4[j*8 +: 8] = mat[r*4+j];
      @(posedge clk); #1;
      if (r == 0) check("busy_after_row0", busy4, 1);
      if (bub && r < 3) begin
        in_valid4 = 1'b0;
        in_data4  = $urandom();
        @(posedge clk); #1;
      end
    end
    in_valid4 = 1'b0;
  endtask

  task automatic wait_out4(input int exp_lat);
    int lat;
    lat = 0;
    while (!out_valid4 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency4", lat, exp_lat);
  endtask

  task automatic drain4(input bit stall);
    int rows;
    int cyc;
    logic [31:0] snap;
    rows = 0;
    cyc  = 0;
    out_ready4 = 1'b1;
    while (rows < 4 && cyc < 200) begin
      if (stall && rows == 1 && out_valid4) begin
        out_ready4 = 1'b0;
        snap = out_data4;
        repeat (10) begin
          @(posedge clk); #1;
          check("stall_valid", out_valid4, 1);
          check("stall_data", out_data4, snap);
        end
        out_ready4 = 1'b1;
      end
      if (out_valid4) begin
        check("last4", out_last4, (rows == 3));
        for (int j = 0; j < 4; j++) check("data4", out_data4[j*8 +: 8], exp_q.pop_front());
        rows++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    check("rows4", rows, 4);
    check("done4_pulse", done4, 1);
    check("ready4_after", in_ready4, 1);
    check("valid4_after", out_valid4, 0);
    out_ready4 = 1'b0;
    @(posedge clk); #1;
    check("done4_low", done4, 0);
    check("valid4_idle", out_valid4, 0);
  endtask

  task automatic load8(input logic [31:0] mat[64], input logic d);
    for (int r = 0; r < 8; r++) begin
      in_valid8 = 1'b1;
      desc8     = d;
      for (int j = 0; j < 8; j++) in_data8[j*32 +: 32] = mat[r*8+j];
      @(posedge clk); #1;
      if (r == 0) begin
        check("busy8_row0", busy8, 1);
        check("done8_low", done8, 0);
      end
    end
    in_valid8 = 1'b0;
  endtask

  task automatic drain8();
    int rows;
    int lat;
    lat = 0;
    while (!out_valid8 && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency8", lat, 56);
    rows = 0;
    out_ready8 = 1'b1;
    while (rows < 8 && lat < 400) begin
      if (out_valid8) begin
        check("last8", out_last8, (rows == 7));
        for (int j = 0; j < 8; j++) check("data8", out_data8[j*32 +: 32], exp_q.pop_front());
        rows++;
      end
      @(posedge clk); #1;
      lat++;
    end
    out_ready8 = 1'b0;
    check("rows8", rows, 8);
    check("done8_pulse", done8, 1);
    check("ready8_with_done", in_ready8, 1);
  endtask

  // Scoreboard reference: plain insertion sort of the whole matrix.
  task automatic push_sorted8(input logic [31:0] mat[64], input logic d);
    logic [31:0] a[64];
    logic [31:0] key;
    int j;
    a = mat;
    for (int i = 1; i < 64; i++) begin
      key = a[i];
      j = i - 1;
      while (j >= 0 && (d ? (a[j] < key) : (a[j] > key))) begin
        a[j+1] = a[j];
        j--;
      end
      a[j+1] = key;
    end
    for (int i = 0; i < 64; i++) exp_q.push_back(a[i]);
  endtask

  initial begin
    logic [7:0]  m4[16];
    logic [31:0] ma[64];
    logic [31:0] mb[64];
    int w;

    checks = 0;
    errors = 0;
    rst = 1'b0;
    in_valid4 = 0; desc4 = 0; in_data4 = '0; out_ready4 = 0;
    in_valid2 = 0; desc2 = 0; in_data2 = '0; out_ready2 = 0;
    in_valid8 = 0; desc8 = 0; in_data8 = '0; out_ready8 = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    check("rst_in_ready", in_ready4, 1);
    check("rst_out_valid", out_valid4, 0);
    check("rst_out_last", out_last4, 0);
    check("rst_busy", busy4, 0);
    check("rst_done", done4, 0);
    check("rst_state", st4, 0);
    check("rst_in_ready8", in_ready8, 1);

    // Reverse load, ascending
    for (int i = 0; i < 16; i++) m4[i] = 8'(15 - i);
    for (int i = 0; i < 16; i++) exp_q.push_back(i);
    load4(m4, 1'b0, 1'b0);
    wait_out4(20);
    drain4(1'b0);

    // Same data, descending
    for (int i = 0; i < 16; i++) exp_q.push_back(15 - i);
    load4(m4, 1'b1, 1'b0);
    wait_out4(20);
    drain4(1'b0);

    // All-equal keys with input bubbles and an output stall
    for (int i = 0; i < 16; i++) m4[i] = 8'd5;
    for (int i = 0; i < 16; i++) exp_q.push_back(5);
    load4(m4, 1'b0, 1'b1);
    wait_out4(20);
    drain4(1'b1);

    // Reset during a column phase
    for (int i = 0; i < 16; i++) m4[i] = 8'(15 - i);
    load4(m4, 1'b0, 1'b0);
    w = 0;
    while (st4 != 2'd2 && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    check("reach_col", st4, 2);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_valid", out_valid4, 0);
    check("midrst_ready", in_ready4, 1);
    check("midrst_busy", busy4, 0);
    rst = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("midrst_no_output", out_valid4, 0);
    for (int i = 0; i < 16; i++) m4[i] = 8'((i * 7) % 16);
    for (int i = 0; i < 16; i++) exp_q.push_back(i);
    load4(m4, 1'b0, 1'b0);
    wait_out4(20);
    drain4(1'b0);

    // N=2 signed and unsigned side by side
    in_valid2 = 1'b1;
    in_data2  = {8'h80, 8'h7F};
    @(posedge clk); #1;
    in_data2  = {8'hFF, 8'h00};
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    w = 0;
    while (!out_valid2s && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    check("latency2", w, 6);
    check("valid2u", out_valid2u, 1);
    out_ready2 = 1'b1;
    check("s_row0", out_data2s, 16'hFF80);
    check("u_row0", out_data2u, 16'h7F00);
    check("s_last0", out_last2s, 0);
    @(posedge clk); #1;
    check("s_row1", out_data2s, 16'h7F00);
    check("u_row1", out_data2u, 16'hFF80);
    check("s_last1", out_last2s, 1);
    @(posedge clk); #1;
    out_ready2 = 1'b0;
    check("done2s", done2s, 1);
    check("done2u", done2u, 1);

    // Back-to-back random 8x8 matrices
    for (int i = 0; i < 64; i++) begin
      ma[i] = $urandom();
      mb[i] = $urandom();
    end
    mb[5] = mb[40];
    push_sorted8(ma, 1'b0);
    load8(ma, 1'b0);
    drain8();
    push_sorted8(mb, 1'b1);
    load8(mb, 1'b1);
    drain8();
    @(posedge clk); #1;
    check("done8_low_end", done8, 0);
    check("exp_q_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
